// File: rtl/pulse_gen_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : pulse_gen_arbiter
// Brief   : Round-robin sharing of one pulseGen between NUM_REQ requesters.
// Revision: 1.0 - initial release
// ============================================================================
module pulse_gen_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int COUNT_W = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*COUNT_W-1:0] req_count,
    input  logic [NUM_REQ-1:0]         req_release,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_REQ-1:0]         done,
    output logic [NUM_REQ-1:0]         err,
    output logic                       busy,
    output logic                       pg_start,
    output logic [COUNT_W-1:0]         pg_pulse_count,
    output logic                       pg_wait_on_me,
    input  logic                       pg_pulse
);

    localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMO_W = $clog2(TIMEOUT) + 1;
    localparam logic [SEL_W-1:0] C_LAST_INIT = SEL_W'(NUM_REQ - 1);
    localparam logic [TMO_W-1:0] C_TMO_LAST  = TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_WAIT_HIGH = 3'd2,
        S_HOLD      = 3'd3,
        S_DONE      = 3'd4,
        S_RECOVER   = 3'd5
    } state_t;

    state_t               r_state;
    logic [SEL_W-1:0]     r_sel;
    logic [SEL_W-1:0]     r_last_grant;
    logic [TMO_W-1:0]     r_tmo_cnt;
    logic [NUM_REQ-1:0]   r_grant;
    logic [NUM_REQ-1:0]   r_done;
    logic [NUM_REQ-1:0]   r_err;
    logic                 r_busy;
    logic                 r_pg_start;
    logic [COUNT_W-1:0]   r_pg_pulse_count;

    logic                 w_found;
    logic [SEL_W-1:0]     w_winner;
    logic [NUM_REQ-1:0]   w_winner_oh;
    logic [COUNT_W-1:0]   w_winner_count;

    // Second loop (candidates above last_grant) overrides the wrapped pass;
    // descending order leaves the lowest index of each pass as the result.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int c = NUM_REQ - 1; c >= 0; c--) begin
            if (req[c] && (SEL_W'(c) <= r_last_grant)) begin
                w_found  = 1'b1;
                w_winner = SEL_W'(c);
            end
        end
        for (int c = NUM_REQ - 1; c >= 0; c--) begin
            if (req[c] && (SEL_W'(c) > r_last_grant)) begin
                w_found  = 1'b1;
                w_winner = SEL_W'(c);
            end
        end
    end

    always_comb begin
        w_winner_count = '0;
        w_winner_oh    = '0;
        for (int c = 0; c < NUM_REQ; c++) begin
            if (SEL_W'(c) == w_winner) begin
                w_winner_count = req_count[c*COUNT_W +: COUNT_W];
                w_winner_oh[c] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= S_IDLE;
            r_sel            <= '0;
            r_last_grant     <= C_LAST_INIT;
            r_tmo_cnt        <= '0;
            r_grant          <= '0;
            r_done           <= '0;
            r_err            <= '0;
            r_busy           <= 1'b0;
            r_pg_start       <= 1'b0;
            r_pg_pulse_count <= '0;
        end else begin
            r_done     <= '0;
            r_err      <= '0;
            r_pg_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_sel            <= w_winner;
                        r_pg_pulse_count <= w_winner_count;
                        r_grant          <= w_winner_oh;
                        r_busy           <= 1'b1;
                        if (w_winner_count == '0) begin
                            r_state <= S_DONE;
                            r_done  <= w_winner_oh;
                        end else begin
                            r_state    <= S_START;
                            r_pg_start <= 1'b1;
                            r_tmo_cnt  <= '0;
                        end
                    end
                end
                S_START: begin
                    // The START cycle counts toward the timeout window.
                    r_state   <= S_WAIT_HIGH;
                    r_tmo_cnt <= r_tmo_cnt + 1'b1;
                end
                S_WAIT_HIGH: begin
                    if (pg_pulse) begin
                        r_state <= S_HOLD;
                    end else if (r_tmo_cnt == C_TMO_LAST) begin
                        r_state      <= S_RECOVER;
                        r_err        <= r_grant;
                        r_grant      <= '0;
                        r_last_grant <= r_sel;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!pg_pulse) begin
                        r_state <= S_DONE;
                        r_done  <= r_grant;
                    end
                end
                S_DONE: begin
                    r_state      <= S_IDLE;
                    r_grant      <= '0;
                    r_busy       <= 1'b0;
                    r_last_grant <= r_sel;
                end
                S_RECOVER: begin
                    if (!pg_pulse) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // A late pulse after timeout is forced to end by holding waitOnMe high.
    always_comb begin
        pg_wait_on_me = 1'b0;
        case (r_state)
            S_HOLD:    pg_wait_on_me = req_release[r_sel];
            S_RECOVER: pg_wait_on_me = 1'b1;
            default:   pg_wait_on_me = 1'b0;
        endcase
    end

    assign grant          = r_grant;
    assign done           = r_done;
    assign err            = r_err;
    assign busy           = r_busy;
    assign pg_start       = r_pg_start;
    assign pg_pulse_count = r_pg_pulse_count;

endmodule
`default_nettype wire

// File: tb/tb_pulse_gen_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_pulse_gen_arbiter
// Brief   : Directed self-checking bench with a behavioural pulseGen stand-in.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pulse_gen_arbiter;

    localparam int NUM_REQ = 4;
    localparam int COUNT_W = 32;
    localparam int TIMEOUT = 16;

    logic                       clk = 1'b0;
    logic                       reset;
    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ*COUNT_W-1:0] req_count;
    logic [NUM_REQ-1:0]         req_release;
    logic [NUM_REQ-1:0]         grant;
    logic [NUM_REQ-1:0]         done;
    logic [NUM_REQ-1:0]         err;
    logic                       busy;
    logic                       pg_start;
    logic [COUNT_W-1:0]         pg_pulse_count;
    logic                       pg_wait_on_me;
    logic                       pg_pulse;

    logic pg_mode;
    logic pg_force;
    logic model_pulse;
    int   model_rem;

    int n_asserts = 0;
    int n_fail    = 0;
    int n_starts  = 0;
    int n_done    = 0;
    int n_err     = 0;
    int s0, d0, e0;
    int exp_order [5] = '{0, 1, 2, 3, 0};

    always #5 clk = ~clk;

    pulse_gen_arbiter #(
        .NUM_REQ (NUM_REQ),
        .COUNT_W (COUNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .req_count      (req_count),
        .req_release    (req_release),
        .grant          (grant),
        .done           (done),
        .err            (err),
        .busy           (busy),
        .pg_start       (pg_start),
        .pg_pulse_count (pg_pulse_count),
        .pg_wait_on_me  (pg_wait_on_me),
        .pg_pulse       (pg_pulse)
    );

    // pulseGen stand-in: high from the cycle after start for at least
    // pulseCount cycles, then until waitOnMe is seen high.
    always @(posedge clk) begin
        if (reset || pg_mode) begin
            model_pulse <= 1'b0;
            model_rem   <= 0;
        end else if (pg_start) begin
            model_pulse <= 1'b1;
            model_rem   <= int'(pg_pulse_count) - 1;
        end else if (model_pulse) begin
            if (model_rem > 0)
                model_rem <= model_rem - 1;
            else if (pg_wait_on_me)
                model_pulse <= 1'b0;
        end
    end

    assign pg_pulse = pg_mode ? pg_force : model_pulse;

    always @(posedge clk) begin
        if (pg_start) n_starts++;
        if (|done)    n_done++;
        if (|err)     n_err++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_count(input int idx, input int val);
        req_count[idx*COUNT_W +: COUNT_W] = COUNT_W'(val);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        req         = '0;
        req_count   = '0;
        req_release = '0;
        pg_mode     = 1'b0;
        pg_force    = 1'b0;

        // ---------------- reset state
        repeat (3) tick();
        check("rst_grant", 64'(grant), 64'h0);
        check("rst_done", 64'(done), 64'h0);
        check("rst_err", 64'(err), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_start", 64'(pg_start), 64'h0);
        check("rst_count", 64'(pg_pulse_count), 64'h0);
        check("rst_wom", 64'(pg_wait_on_me), 64'h0);
        reset = 1'b0;
        tick();
        check("idle_busy", 64'(busy), 64'h0);

        // ---------------- single request
        set_count(0, 5);
        req = 4'b0001;
        s0  = n_starts;
        tick();
        check("s_grant", 64'(grant), 64'h1);
        check("s_start", 64'(pg_start), 64'h1);
        check("s_count", 64'(pg_pulse_count), 64'd5);
        check("s_busy", 64'(busy), 64'h1);
        check("s_wom_start", 64'(pg_wait_on_me), 64'h0);
        req = 4'b0000;
        tick();
        check("s_start_drop", 64'(pg_start), 64'h0);
        check("s_pulse_up", 64'(pg_pulse), 64'h1);
        tick();
        check("s_wom_hold0", 64'(pg_wait_on_me), 64'h0);
        set_count(0, 9);
        repeat (9) tick();
        check("s_count_stable", 64'(pg_pulse_count), 64'd5);
        check("s_grant_hold", 64'(grant), 64'h1);
        req_release[0] = 1'b1;
        #1;
        check("s_wom_hold1", 64'(pg_wait_on_me), 64'h1);
        tick();
        check("s_pulse_down", 64'(pg_pulse), 64'h0);
        check("s_done_early", 64'(done), 64'h0);
        tick();
        check("s_done", 64'(done), 64'h1);
        check("s_done_grant", 64'(grant), 64'h1);
        check("s_done_wom", 64'(pg_wait_on_me), 64'h0);
        tick();
        check("s_done_clear", 64'(done), 64'h0);
        check("s_grant_clear", 64'(grant), 64'h0);
        check("s_busy_clear", 64'(busy), 64'h0);
        check("s_one_start", 64'(n_starts - s0), 64'd1);
        req_release = '0;

        // ---------------- round robin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        for (int i = 0; i < NUM_REQ; i++) set_count(i, 3);
        req_release = 4'b1111;
        req         = 4'b1111;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("rr_start", 64'(pg_start), 64'h1);
            check("rr_grant", 64'(grant), 64'(4'b0001 << exp_order[i]));
            s0 = n_starts;
            repeat (5) tick();
            check("rr_done", 64'(done), 64'(4'b0001 << exp_order[i]));
            check("rr_one_start", 64'(n_starts - s0), 64'd1);
            if (i == 4) req = 4'b0000;
            tick();
            check("rr_idle_gap", 64'(pg_start), 64'h0);
            tick();
        end
        check("rr_final_busy", 64'(busy), 64'h0);
        check("rr_final_start", 64'(pg_start), 64'h0);

        // ---------------- timeout
        pg_mode  = 1'b1;
        pg_force = 1'b0;
        set_count(1, 7);
        req = 4'b0010;
        tick();
        check("t_start", 64'(pg_start), 64'h1);
        check("t_grant", 64'(grant), 64'h2);
        req = 4'b0000;
        e0  = n_err;
        d0  = n_done;
        repeat (15) tick();
        check("t_err_early", 64'(err), 64'h0);
        check("t_grant_wait", 64'(grant), 64'h2);
        tick();
        check("t_err", 64'(err), 64'h2);
        check("t_grant_drop", 64'(grant), 64'h0);
        check("t_done_none", 64'(done), 64'h0);
        check("t_rec_busy", 64'(busy), 64'h1);
        check("t_rec_wom", 64'(pg_wait_on_me), 64'h1);
        pg_force = 1'b1;
        tick();
        check("t_err_once", 64'(err), 64'h0);
        check("t_rec_hold", 64'(busy), 64'h1);
        tick();
        check("t_rec_hold2", 64'(busy), 64'h1);
        pg_force = 1'b0;
        tick();
        check("t_rec_exit", 64'(busy), 64'h0);
        check("t_err_count", 64'(n_err - e0), 64'd1);
        check("t_done_count", 64'(n_done - d0), 64'd0);
        pg_mode = 1'b0;
        set_count(0, 2);
        req = 4'b0011;
        tick();
        check("t_next_grant", 64'(grant), 64'h1);
        check("t_next_start", 64'(pg_start), 64'h1);
        req = 4'b0000;
        repeat (4) tick();
        check("t_next_done", 64'(done), 64'h1);
        tick();

        // ---------------- zero count
        set_count(2, 0);
        req = 4'b0100;
        s0  = n_starts;
        tick();
        check("z_grant", 64'(grant), 64'h4);
        check("z_done", 64'(done), 64'h4);
        check("z_start", 64'(pg_start), 64'h0);
        check("z_count", 64'(pg_pulse_count), 64'h0);
        check("z_busy", 64'(busy), 64'h1);
        set_count(0, 2);
        req = 4'b0101;
        tick();
        check("z_grant_gone", 64'(grant), 64'h0);
        check("z_no_start", 64'(n_starts - s0), 64'd0);
        tick();
        check("z_next_grant", 64'(grant), 64'h1);
        check("z_next_start", 64'(pg_start), 64'h1);
        req = 4'b0000;
        repeat (4) tick();
        check("z_next_done", 64'(done), 64'h1);
        tick();

        // ---------------- reset mid-HOLD
        req_release = 4'b1101;
        set_count(1, 4);
        req = 4'b0010;
        d0  = n_done;
        e0  = n_err;
        tick();
        check("r_grant", 64'(grant), 64'h2);
        req = 4'b0000;
        repeat (2) tick();
        check("r_hold_grant", 64'(grant), 64'h2);
        check("r_hold_pulse", 64'(pg_pulse), 64'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("r_grant0", 64'(grant), 64'h0);
        check("r_done0", 64'(done), 64'h0);
        check("r_err0", 64'(err), 64'h0);
        check("r_busy0", 64'(busy), 64'h0);
        check("r_start0", 64'(pg_start), 64'h0);
        check("r_count0", 64'(pg_pulse_count), 64'h0);
        check("r_wom0", 64'(pg_wait_on_me), 64'h0);
        tick();
        check("r_no_done", 64'(n_done - d0), 64'd0);
        check("r_no_err", 64'(n_err - e0), 64'd0);
        req_release = 4'b1111;
        set_count(0, 2);
        set_count(1, 2);
        req = 4'b0011;
        tick();
        check("r_after_grant", 64'(grant), 64'h1);
        req = 4'b0000;
        repeat (4) tick();
        check("r_after_done", 64'(done), 64'h1);
        tick();

        // ---------------- late release
        req_release = 4'b1101;
        set_count(1, 3);
        req = 4'b0010;
        e0  = n_err;
        tick();
        check("l_grant", 64'(grant), 64'h2);
        req = 4'b0000;
        repeat (2) tick();
        for (int k = 0; k < 40; k++) begin
            check("l_grant_hold", 64'(grant), 64'h2);
            tick();
        end
        check("l_pulse_high", 64'(pg_pulse), 64'h1);
        check("l_no_err", 64'(n_err - e0), 64'd0);
        check("l_wom0", 64'(pg_wait_on_me), 64'h0);
        req_release = 4'b1111;
        #1;
        check("l_wom1", 64'(pg_wait_on_me), 64'h1);
        tick();
        check("l_pulse_down", 64'(pg_pulse), 64'h0);
        check("l_done_early", 64'(done), 64'h0);
        tick();
        check("l_done", 64'(done), 64'h2);
        tick();
        check("l_busy_end", 64'(busy), 64'h0);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
